// File: rtl/pc_ras_unit_pkg.sv
// Shared types for the fetch-stage PC with return-address stack.
package pc_ras_unit_pkg;

   localparam int ADDR_W = 26;

   typedef logic [31:0] word_t;

   // Next-PC source select.
   typedef enum logic [2:0] {
      PC_NPC = 3'd0,
      PC_BR  = 3'd1,
      PC_J   = 3'd2,
      PC_JR  = 3'd3,
      PC_RET = 3'd4
   } pc_ms;

   // Width of a RAS pointer for a given depth.
   function automatic int ras_ptr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/pc_ras_unit_if.sv
// Control/hazard unit <-> program counter bundle.
interface pc_ras_unit_if;
   import pc_ras_unit_pkg::*;

   logic              en;
   pc_ms              sel;
   word_t             ext32;
   logic [ADDR_W-1:0] jump_a;
   word_t             jr_a;
   logic              call;
   logic              flush;
   word_t             flush_a;
   word_t             val;
   logic              ras_empty;
   logic              ras_ovf;

   modport master (
      output en, sel, ext32, jump_a, jr_a, call, flush, flush_a,
      input  val, ras_empty, ras_ovf
   );

   modport slave (
      input  en, sel, ext32, jump_a, jr_a, call, flush, flush_a,
      output val, ras_empty, ras_ovf
   );

endinterface

// File: rtl/pc_ras_unit_ras.sv
// pc_ras: circular return-address stack with saturating count and a
// sticky overflow flag. Top read is combinational.
module pc_ras
   import pc_ras_unit_pkg::*;
#(
   parameter int RAS_DEPTH = 4
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  push,
   input  logic  pop,
   input  word_t push_d,
   output word_t top_d,
   output logic  empty,
   output logic  ovf
);

   localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

   word_t            mem [RAS_DEPTH];
   logic [PTR_W-1:0] top;
   logic [PTR_W:0]   cnt;
   logic             pop_ok;

   // Popping an empty stack is a no-op.
   assign pop_ok = pop & (cnt != '0);
   assign empty  = (cnt == '0);
   assign top_d  = mem[top];

   // Pointer, count and overflow flag.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         top <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (push && !pop_ok) begin
         top <= top + 1'b1;
         if (cnt == FULL) ovf <= 1'b1;
         else             cnt <= cnt + 1'b1;
      end else if (pop_ok && !push) begin
         top <= top - 1'b1;
         cnt <= cnt - 1'b1;
      end
   end

   // Entry storage; push+pop rewrites the current top in place.
   always_ff @(posedge CLK) begin
      if (push && pop_ok)  mem[top]        <= push_d;
      else if (push)       mem[top + 1'b1] <= push_d;
   end

endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: fetch-stage PC with next-PC mux and optional RAS.
// Define PC_RAS_EN to build the return-address stack; otherwise PC_RET
// acts as PC_JR, call is ignored and the RAS flags are tied off.
module pc_ras_unit
   import pc_ras_unit_pkg::*;
#(
   parameter word_t PC_INIT   = 32'h0000_0000,
   parameter int    RAS_DEPTH = 4
) (
   input  logic         CLK,
   input  logic         nRST,
   pc_ras_unit_if.slave pcif
);

   word_t pc, npc, br_a, j_a, ret_a, nxt;

   assign npc  = pc + 32'd4;
   assign br_a = npc + {pcif.ext32[29:0], 2'b00};
   assign j_a  = {npc[31:28], pcif.jump_a, 2'b00};

`ifdef PC_RAS_EN
   logic  push, pop;
   word_t top_d;

   assign push = pcif.en & pcif.call & ~pcif.flush;
   assign pop  = pcif.en & (pcif.sel == PC_RET) & ~pcif.flush;

   pc_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
      .CLK    (CLK),
      .nRST   (nRST),
      .push   (push),
      .pop    (pop),
      .push_d (npc),
      .top_d  (top_d),
      .empty  (pcif.ras_empty),
      .ovf    (pcif.ras_ovf)
   );

   // Empty stack falls back to the register target.
   assign ret_a = pcif.ras_empty ? pcif.jr_a : top_d;
`else
   logic unused_call;
   localparam int unused_depth = RAS_DEPTH;

   assign unused_call    = pcif.call;
   assign ret_a          = pcif.jr_a;
   assign pcif.ras_empty = 1'b1;
   assign pcif.ras_ovf   = 1'b0;
`endif

   // Next-PC select: flush wins over everything, then en-gated sources.
   always_comb begin
      nxt = pc;
      if (pcif.flush) begin
         nxt = pcif.flush_a;
      end else if (pcif.en) begin
         case (pcif.sel)
            PC_NPC:  nxt = npc;
            PC_BR:   nxt = br_a;
            PC_J:    nxt = j_a;
            PC_JR:   nxt = pcif.jr_a;
            PC_RET:  nxt = ret_a;
            default: nxt = pc;
         endcase
      end
   end

   // Fetch PC register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) pc <= PC_INIT;
      else       pc <= nxt;
   end

   assign pcif.val = pc;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: stimulus pushes expected state after
// each edge, a monitor pops and compares on the falling edge (or on demand
// for the asynchronous reset check).
module tb_pc_ras_unit;
   import pc_ras_unit_pkg::*;

`ifdef PC_RAS_EN
   localparam bit R = 1'b1;
`else
   localparam bit R = 1'b0;
`endif

   typedef struct {
      string name;
      word_t v;
      logic  em;
      logic  ov;
   } exp_t;

   logic CLK = 1'b0;
   logic nRST;
   int   tests = 0;
   int   fails = 0;
   bit   done  = 1'b0;
   exp_t exp_q[$];
   event chk_now;

   pc_ras_unit_if pcif ();

   pc_ras_unit #(.PC_INIT(32'h0000_0200), .RAS_DEPTH(4)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .pcif (pcif)
   );

   always #5 CLK = ~CLK;

   function automatic word_t rs(input word_t a, input word_t b);
      return R ? a : b;
   endfunction

   task automatic drv(input logic e, input pc_ms s, input logic c, input logic f,
                      input word_t x, input logic [25:0] ja, input word_t jr, input word_t fa);
      pcif.en = e; pcif.sel = s; pcif.call = c; pcif.flush = f;
      pcif.ext32 = x; pcif.jump_a = ja; pcif.jr_a = jr; pcif.flush_a = fa;
   endtask

   task automatic tick(input string n, input word_t v, input logic em, input logic ov);
      @(posedge CLK);
      #1;
      exp_q.push_back('{n, v, em, ov});
   endtask

   // Monitor: compare DUT state against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK or chk_now);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (pcif.val !== e.v || pcif.ras_empty !== e.em || pcif.ras_ovf !== e.ov) begin
               fails++;
               $display("FAIL %s: val=%h empty=%b ovf=%b, required val=%h empty=%b ovf=%b",
                        e.name, pcif.val, pcif.ras_empty, pcif.ras_ovf, e.v, e.em, e.ov);
            end
         end
         if (done && exp_q.size() == 0) begin
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      nRST = 1'b0;
      drv(0, PC_NPC, 0, 0, 0, 0, 0, 0);
      exp_q.push_back('{"reset", 32'h200, 1'b1, 1'b0});
      @(posedge CLK); #1;
      nRST = 1'b1;

      // Sequential and basic redirects.
      drv(1, PC_NPC, 0, 0, 0, 0, 0, 0);
      tick("npc1", 32'h204, 1, 0);
      tick("npc2", 32'h208, 1, 0);
      tick("npc3", 32'h20C, 1, 0);
      drv(1, PC_JR, 0, 0, 0, 0, 32'h100, 0);            tick("jr100", 32'h100, 1, 0);
      drv(1, PC_BR, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);      tick("br_neg", 32'h100, 1, 0);
      drv(1, PC_J, 0, 0, 0, 26'h0000040, 0, 0);         tick("j40", 32'h100, 1, 0);
      drv(1, PC_JR, 0, 0, 0, 0, 32'h300, 0);            tick("jr300", 32'h300, 1, 0);
      drv(1, PC_JR, 0, 0, 0, 0, 32'h40, 0);             tick("jr40", 32'h40, 1, 0);

      // Call then return.
      drv(1, PC_J, 1, 0, 0, 26'h400, 0, 0);             tick("call_j", 32'h1000, ~R, 0);
      drv(1, PC_NPC, 0, 0, 0, 0, 0, 0);                 tick("after_call", 32'h1004, ~R, 0);
      drv(1, PC_RET, 0, 0, 0, 0, 32'hDEAD, 0);          tick("ret1", rs(32'h44, 32'hDEAD), 1, 0);

      // Overflow: five calls into a four-deep stack.
      drv(1, PC_JR, 0, 0, 0, 0, 32'h10, 0);             tick("jr10", 32'h10, 1, 0);
      drv(1, PC_JR, 1, 0, 0, 0, 32'h20, 0);             tick("call1", 32'h20, ~R, 0);
      drv(1, PC_JR, 1, 0, 0, 0, 32'h30, 0);             tick("call2", 32'h30, ~R, 0);
      drv(1, PC_JR, 1, 0, 0, 0, 32'h40, 0);             tick("call3", 32'h40, ~R, 0);
      drv(1, PC_JR, 1, 0, 0, 0, 32'h50, 0);             tick("call4", 32'h50, ~R, 0);
      drv(1, PC_JR, 1, 0, 0, 0, 32'h60, 0);             tick("call5_ovf", 32'h60, ~R, R);
      drv(1, PC_RET, 0, 0, 0, 0, 32'h900, 0);           tick("ret_a", rs(32'h54, 32'h900), ~R, R);
      drv(1, PC_RET, 0, 0, 0, 0, 32'h910, 0);           tick("ret_b", rs(32'h44, 32'h910), ~R, R);
      drv(1, PC_RET, 0, 0, 0, 0, 32'h920, 0);           tick("ret_c", rs(32'h34, 32'h920), ~R, R);
      drv(1, PC_RET, 0, 0, 0, 0, 32'h930, 0);           tick("ret_d", rs(32'h24, 32'h930), 1, R);
      drv(1, PC_RET, 0, 0, 0, 0, 32'h940, 0);           tick("ret_empty", 32'h940, 1, R);

      // Flush ignores en and does not push even with call high.
      drv(1, PC_NPC, 1, 0, 0, 0, 0, 0);                 tick("call_npc", 32'h944, ~R, R);
      drv(0, PC_NPC, 1, 1, 0, 0, 0, 32'h800);           tick("flush", 32'h800, ~R, R);
      drv(1, PC_RET, 0, 0, 0, 0, 32'h111, 0);           tick("ret_after_flush", rs(32'h944, 32'h111), 1, R);
      drv(1, PC_RET, 0, 0, 0, 0, 32'h222, 0);           tick("ret_drained", 32'h222, 1, R);

      // Jump region bits and 32-bit wrap, forward branch.
      drv(1, PC_JR, 0, 0, 0, 0, 32'hF000_0010, 0);      tick("jr_hi", 32'hF000_0010, 1, R);
      drv(1, PC_J, 0, 0, 0, 26'h3FF_FFFF, 0, 0);        tick("j_region", 32'hFFFF_FFFC, 1, R);
      drv(1, PC_NPC, 0, 0, 0, 0, 0, 0);                 tick("npc_wrap", 32'h0, 1, R);
      drv(1, PC_BR, 0, 0, 32'h10, 0, 0, 0);             tick("br_fwd", 32'h44, 1, R);

      // Stall: PC and RAS frozen even with call asserted.
      drv(0, PC_JR, 1, 0, 0, 0, 32'h555, 0);
      tick("stall1", 32'h44, 1, R);
      tick("stall2", 32'h44, 1, R);
      tick("stall3", 32'h44, 1, R);
      drv(1, PC_RET, 0, 0, 0, 0, 32'h666, 0);           tick("ret_after_stall", 32'h666, 1, R);

      // Asynchronous reset in the middle of a stall.
      drv(0, PC_JR, 0, 0, 0, 0, 32'h555, 0);
      tick("stall4", 32'h666, 1, R);
      @(negedge CLK); #1;
      nRST = 1'b0;
      exp_q.push_back('{"async_reset", 32'h200, 1'b1, 1'b0});
      #1;
      -> chk_now;
      tests++;
      if (pcif.val !== 32'h200) begin
         fails++;
         $display("FAIL async_reset_val: val=%h, required 00000200", pcif.val);
      end
      tests++;
      if (pcif.ras_empty !== 1'b1) begin
         fails++;
         $display("FAIL async_reset_empty: empty=%b, required 1", pcif.ras_empty);
      end
      tests++;
      if (pcif.ras_ovf !== 1'b0) begin
         fails++;
         $display("FAIL async_reset_ovf: ovf=%b, required 0", pcif.ras_ovf);
      end
      #1;
      nRST = 1'b1;
      drv(1, PC_NPC, 0, 0, 0, 0, 0, 0);                 tick("npc_post_reset", 32'h204, 1, 0);
      tests++;
      if (pcif.val !== 32'h204) begin
         fails++;
         $display("FAIL npc_post_reset_direct: val=%h, required 00000204", pcif.val);
      end

      done = 1'b1;
   end

endmodule

// File: doc/pc_ras_unit.md
# pc_ras_unit

Parametrised fetch-stage program counter with a built-in return-address stack (RAS). It holds the current fetch address and selects the next PC from sequential, branch, jump, register-jump, predicted-return and flush-redirect sources. The RAS, with configurable depth, predicts `jr $31` targets. It sits between the control/hazard unit and instruction memory and replaces the fixed single-mode PC.

## Interface
Parameters:
- `PC_INIT`, `32'h0000_0000`: reset fetch address.
- `RAS_DEPTH`, `4`: RAS entries; power of two, 2..16.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance PC this cycle; low = stall.
- `sel`  in  `pc_ms`  next-PC source: `PC_NPC`, `PC_BR`, `PC_J`, `PC_JR`, `PC_RET`.
- `ext32`  in  32  sign-extended branch immediate, not yet shifted.
- `jump_a`  in  `ADDR_W` (26)  J-type target field.
- `jr_a`  in  32  register-jump target.
- `call`  in  1  current instruction is `jal`/`jalr`; push return address.
- `flush`  in  1  EX-stage mispredict redirect.
- `flush_a`  in  32  redirect target.
- `val`  out  32  current fetch PC.
- `ras_empty`  out  1  RAS holds no valid entry.
- `ras_ovf`  out  1  sticky flag: a push overwrote a valid entry.

## Operation
- `npc = val + 4`, 32-bit wrap; carry discarded.
- Next PC by priority:
  - `flush` → `flush_a`; ignores `en`; RAS unchanged.
  - `en` with `PC_NPC` → `npc`.
  - `en` with `PC_BR` → `npc + (ext32 << 2)`, mod 2^32.
  - `en` with `PC_J` → `{npc[31:28], jump_a, 2'b00}`.
  - `en` with `PC_JR` → `jr_a`.
  - `en` with `PC_RET` → RAS top if non-empty, else `jr_a`.
  - Otherwise hold.
- RAS is circular. It has a top pointer and a count that saturates at `RAS_DEPTH`.
- Push (`en & call & !flush`) writes `npc` at top+1 and advances top. If count is already `RAS_DEPTH`, the oldest entry is overwritten and `ras_ovf` is set.
- Pop (`en & sel==PC_RET & !flush`) retreats top and decrements count when non-empty. Popping an empty stack changes nothing.
- Push and pop in the same cycle (`jalr` to a return) replace the top entry with `npc`. Count and pointer are unchanged.
- `en` low freezes the PC and the RAS.

## Timing
- `val` is registered. Next-PC selection is combinational and the PC and RAS update on the same edge.
- One-cycle latency: inputs sampled at edge N appear on `val` after edge N.
- RAS top read is combinational, so a push at edge N can be popped at edge N+1.
- Reset, asynchronous (including mid-operation): `val=PC_INIT`, count=0, top=0, `ras_empty=1`, `ras_ovf=0`. RAS data contents are don't-care.
- `ras_empty` and `ras_ovf` are registered-state outputs, valid in the same cycle as `val`.
- `ras_ovf` clears only on reset.

## Configuration
- `PC_RAS_EN` defined: RAS is instantiated as described above.
- `PC_RAS_EN` undefined:
  - No RAS storage.
  - `PC_RET` behaves exactly as `PC_JR`.
  - `call` is ignored.
  - `ras_empty` ties to 1 and `ras_ovf` ties to 0.
  - The port list is unchanged.

## Structure
- Add `PC_RET` to the `pc_ms` enum in `mux_signals`.
- Add to `cpu_types_pkg`: `RAS_PTR_W = $clog2(RAS_DEPTH)` helper and `word_t`.
- Extend `program_counter_if` with `call`, `flush`, `flush_a`, `ras_empty` and `ras_ovf`.
- One sub-module, `pc_ras`: circular stack with push/pop/top, count, and overflow flag, parametrised by `RAS_DEPTH`.

## Test plan
- Reset with `PC_INIT=32'h0000_0200` → `val=0x200`, `ras_empty=1`; 3 cycles of `en`/`PC_NPC` → `0x204`, `0x208`, `0x20C`.
- At `val=0x100`: `PC_BR`, `ext32=32'hFFFF_FFFF` → `0x100`; `PC_J`, `jump_a=26'h0000040` → `0x100`; `PC_JR`, `jr_a=0x300` → `0x300`.
- `call`+`PC_J` at `val=0x40` → RAS top `0x44`; later `PC_RET` with `jr_a=0xDEAD` → `val=0x44`, `ras_empty=1`.
- `RAS_DEPTH=4`: 5 calls at `0x10`, `0x20`, `0x30`, `0x40`, `0x50` → `ras_ovf=1`; 4 returns yield `0x54`, `0x44`, `0x34`, `0x24`; 5th return uses `jr_a`.
- `flush=1`, `flush_a=0x800` with `en=0` and `call=1` → `val=0x800`, RAS count unchanged.
- `en=0` for 3 cycles with `sel=PC_JR` → `val` held; assert `nRST` mid-stall → `val=PC_INIT` immediately, without waiting for a clock edge.
